ex_muldiv: RTL

Iterative multiply/divide unit for the EX stage, implementing the RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for a parametrised data width. It sits beside the single-cycle ALU. EX issues a start pulse with already-forwarded operands and holds the pipeline until `done_o`. Operands are latched at start; the result is held until the next accepted start.

---
 rtl/ex_muldiv.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide, XLEN cycles each, plus a sign fixup cycle.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] oper1_i,
    input  logic [XLEN-1:0] oper2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_op;
    logic [XLEN-1:0]     r_b;
    logic                r_neg;
    logic                r_rem_neg;
    logic [CW-1:0]       r_cnt;
    logic [2*XLEN-1:0]   r_prod;
    logic [XLEN-1:0]     r_result;

    logic                w_sign1;
    logic                w_sign2;
    logic [XLEN-1:0]     w_mag1;
    logic [XLEN-1:0]     w_mag2;
    logic                w_accept;
    logic                w_div_zero;
    logic                w_ovf;
    logic                w_fast;
    logic [XLEN-1:0]     w_fast_res;
    logic [XLEN:0]       w_sum;
    logic [XLEN:0]       w_shift;
    logic [XLEN:0]       w_diff;
    logic [2*XLEN-1:0]   w_step;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quo_fix;
    logic [XLEN-1:0]     w_rem_fix;
    logic [XLEN-1:0]     w_fix_res;

    // Handshake: start_i is taken only in IDLE or DONE with flush_i low; result_o is valid
    // in the single done_o cycle and held until the next taken start.
    always_comb begin
        w_sign1    = (op_i == 3'd1 || op_i == 3'd2 || op_i == 3'd4 || op_i == 3'd6) && oper1_i[XLEN-1];
        w_sign2    = (op_i == 3'd1 || op_i == 3'd4 || op_i == 3'd6) && oper2_i[XLEN-1];
        w_mag1     = w_sign1 ? -oper1_i : oper1_i;
        w_mag2     = w_sign2 ? -oper2_i : oper2_i;
        w_accept   = start_i && !flush_i && (r_state == S_IDLE || r_state == S_DONE);
        w_div_zero = op_i[2] && (oper2_i == '0);
        w_ovf      = (op_i == 3'd4 || op_i == 3'd6) && (oper1_i == MIN_NEG) && (oper2_i == ALL_ONES);
        w_fast     = w_div_zero || w_ovf;
        if (w_div_zero) begin
            w_fast_res = op_i[1] ? oper1_i : ALL_ONES;
        end else begin
            w_fast_res = op_i[1] ? '0 : MIN_NEG;
        end
    end

    // Low half of r_prod holds the multiplier (shifted out right) or the dividend (shifted out left).
    always_comb begin
        w_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_b} : '0);
        w_shift = r_prod[2*XLEN-1:XLEN-1];
        w_diff  = w_shift - {1'b0, r_b};
        if (!r_op[2]) begin
            w_step = {w_sum, r_prod[XLEN-1:1]};
        end else if (w_diff[XLEN]) begin
            w_step = {w_shift[XLEN-1:0], r_prod[XLEN-2:0], 1'b0};
        end else begin
            w_step = {w_diff[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};
        end
    end

    always_comb begin
        w_prod_fix = r_neg ? -r_prod : r_prod;
        w_quo_fix  = r_neg ? -r_prod[XLEN-1:0] : r_prod[XLEN-1:0];
        w_rem_fix  = r_rem_neg ? -r_prod[2*XLEN-1:XLEN] : r_prod[2*XLEN-1:XLEN];
        case (r_op)
            3'd0:          w_fix_res = w_prod_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:    w_fix_res = w_quo_fix;
            default:       w_fix_res = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_next = w_fast ? S_DONE : S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CALC:  if (r_cnt == '0) w_next = S_FIXUP;
            S_FIXUP: w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (flush_i) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op      <= '0;
            r_b       <= '0;
            r_neg     <= 1'b0;
            r_rem_neg <= 1'b0;
            r_cnt     <= '0;
            r_prod    <= '0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_op      <= op_i;
            r_b       <= w_mag2;
            r_neg     <= w_sign1 ^ w_sign2;
            r_rem_neg <= w_sign1;
            r_cnt     <= CW'(XLEN - 1);
            r_prod    <= {{XLEN{1'b0}}, w_mag1};
            if (w_fast) begin
                r_result <= w_fast_res;
            end
        end else if (r_state == S_CALC) begin
            r_prod <= w_step;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end else if (r_state == S_FIXUP && !flush_i) begin
            r_result <= w_fix_res;
        end
    end

    assign busy_o      = (r_state == S_CALC) || (r_state == S_FIXUP);
    assign done_o      = (r_state == S_DONE);
    assign result_o    = r_result;
    assign dbg_state_o = r_state;

endmodule
